// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: one classic Wishbone master shared by the fetch and data ports, data port first.
// Define BUS_TIMEOUT_EN to abort bus cycles that are not acknowledged within TIMEOUT_CYCLES.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_busy,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_sel,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_busy,
    output logic                    bus_err,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        MEM_ACC,
        IF_ACC,
        MEM_DONE,
        IF_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic                  timeout_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_RAW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_WIDTH = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 bus_err_q, bus_err_d;
    logic                 in_access;

    assign in_access = (state_q == MEM_ACC) || (state_q == IF_ACC);

    // Counter is zero on the first access cycle and counts unacknowledged cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (in_access && !wb_ack_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    assign timeout_hit = in_access && !wb_ack_i &&
                         (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign bus_err_d   = timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d = MEM_ACC;
                    cyc_d   = 1'b1;
                    we_d    = mem_we;
                    adr_d   = mem_addr;
                    dat_d   = mem_wdata;
                    sel_d   = mem_sel;
                end else if (if_req) begin
                    state_d = IF_ACC;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = if_addr;
                    sel_d   = '1;
                end
            end
            MEM_ACC: begin
                if (wb_ack_i) begin
                    state_d = MEM_DONE;
                    cyc_d   = 1'b0;
                    if (!we_q) begin
                        mem_rdata_d = wb_dat_i;
                    end
                end else if (timeout_hit) begin
                    state_d     = MEM_DONE;
                    cyc_d       = 1'b0;
                    mem_rdata_d = '0;
                end
            end
            IF_ACC: begin
                if (wb_ack_i) begin
                    state_d    = IF_DONE;
                    cyc_d      = 1'b0;
                    if_rdata_d = wb_dat_i;
                end else if (timeout_hit) begin
                    state_d    = IF_DONE;
                    cyc_d      = 1'b0;
                    if_rdata_d = '0;
                end
            end
            // A completion always passes through IDLE so the winner is re-arbitrated.
            MEM_DONE, IF_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    // Busy drops for exactly the one DONE cycle so the pipeline advances once.
    assign mem_busy = mem_req && (state_q != MEM_DONE);
    assign if_busy  = if_req && (state_q != IF_DONE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: the bench plays the Wishbone slave and predicts
// bus fields, busy handshakes and returned data from the port-level rules.
module tb_mem_bus_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_busy;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_sel;
    logic [DW-1:0] mem_rdata;
    logic          mem_busy;
    logic          bus_err;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] expIfRdata;
    logic [DW-1:0] expMemRdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_busy   (if_busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_sel   (mem_sel),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .bus_err   (bus_err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [AW-1:0] ifAddr,
                                 input logic memReq, input logic memWe,
                                 input logic [AW-1:0] memAddr, input logic [DW-1:0] memWdata,
                                 input logic [SW-1:0] memSel);
        if_req    = ifReq;
        if_addr   = ifAddr;
        mem_req   = memReq;
        mem_we    = memWe;
        mem_addr  = memAddr;
        mem_wdata = memWdata;
        mem_sel   = memSel;
        #1;
    endtask

    // Entered on the first cycle the strobe should be up; returns in the DONE cycle.
    // The owning port's request fields are scrambled to prove the bus fields were latched.
    task automatic busCycle(input bit isMem, input logic we, input logic [AW-1:0] adr,
                            input logic [DW-1:0] wdat, input logic [SW-1:0] sel,
                            input int waits, input bit flush, input bit lateMem,
                            input logic [DW-1:0] ackData, input string tag);
        for (int w = 0; w <= waits; w++) begin
            wb_ack_i = (w == waits);
            wb_dat_i = (w == waits) ? ackData : DW'($urandom);
            if (isMem) begin
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_sel   = SW'($urandom);
                mem_we    = ~we;
                if (flush) mem_req = 1'b0;
            end else begin
                if_addr = $urandom;
                if (flush) if_req = 1'b0;
            end
            if (lateMem) mem_req = 1'b1;
            #1;
            checkOutput({tag, ".cyc"}, wb_cyc_o, 1);
            checkOutput({tag, ".stb"}, wb_stb_o, 1);
            checkOutput({tag, ".adr"}, wb_adr_o, adr);
            checkOutput({tag, ".we"}, wb_we_o, we);
            checkOutput({tag, ".sel"}, wb_sel_o, sel);
            if (isMem && we) checkOutput({tag, ".dat"}, wb_dat_o, wdat);
            checkOutput({tag, ".ifBusy"}, if_busy, if_req);
            checkOutput({tag, ".memBusy"}, mem_busy, mem_req);
            checkOutput({tag, ".busErr"}, bus_err, 0);
            nextCycle();
        end
        wb_ack_i = 1'($urandom_range(0, 1));
        wb_dat_i = DW'($urandom);
        #1;
        if (isMem && !we) expMemRdata = ackData;
        if (!isMem) expIfRdata = ackData;
        checkOutput({tag, ".doneCyc"}, wb_cyc_o, 0);
        checkOutput({tag, ".doneStb"}, wb_stb_o, 0);
        checkOutput({tag, ".ifRdata"}, if_rdata, expIfRdata);
        checkOutput({tag, ".memRdata"}, mem_rdata, expMemRdata);
        checkOutput({tag, ".doneIfBusy"}, if_busy, isMem ? if_req : 1'b0);
        checkOutput({tag, ".doneMemBusy"}, mem_busy, isMem ? 1'b0 : mem_req);
        checkOutput({tag, ".doneBusErr"}, bus_err, 0);
    endtask

    initial begin
        int            kind;
        int            waits;
        bit            flush;
        logic          rndWe;
        logic [AW-1:0] ia;
        logic [AW-1:0] ma;
        logic [DW-1:0] wd;
        logic [SW-1:0] sel;

        reset       = 1'b0;
        wb_dat_i    = '0;
        wb_ack_i    = 1'b0;
        expIfRdata  = '0;
        expMemRdata = '0;
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        #1;
        checkOutput("reset.cyc", wb_cyc_o, 0);
        checkOutput("reset.stb", wb_stb_o, 0);
        checkOutput("reset.we", wb_we_o, 0);
        checkOutput("reset.adr", wb_adr_o, 0);
        checkOutput("reset.dat", wb_dat_o, 0);
        checkOutput("reset.sel", wb_sel_o, 0);
        checkOutput("reset.ifRdata", if_rdata, 0);
        checkOutput("reset.memRdata", mem_rdata, 0);
        checkOutput("reset.busErr", bus_err, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        nextCycle();
        $display("[TB] reset released");

        // Fetch only with zero wait states, then a second fetch that must re-arbitrate via IDLE.
        applyStimulus(1, 32'h8000_0000, 0, 0, '0, '0, '0);
        checkOutput("fetch.idleBusy", if_busy, 1);
        checkOutput("fetch.idleCyc", wb_cyc_o, 0);
        nextCycle();
        busCycle(0, 0, 32'h8000_0000, '0, 4'hF, 0, 0, 0, 32'h0000_0013, "fetch");
        applyStimulus(1, 32'h8000_0004, 0, 0, '0, '0, '0);
        nextCycle();
        checkOutput("fetch2.idleBusy", if_busy, 1);
        checkOutput("fetch2.idleCyc", wb_cyc_o, 0);
        nextCycle();
        busCycle(0, 0, 32'h8000_0004, '0, 4'hF, 2, 0, 0, 32'h0010_0093, "fetch2");
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        nextCycle();

        // Simultaneous requests: data port first, fetch only after the data completion.
        applyStimulus(1, 32'h8000_0100, 1, 0, 32'h8040_0000, '0, 4'hF);
        checkOutput("simul.idleIfBusy", if_busy, 1);
        checkOutput("simul.idleMemBusy", mem_busy, 1);
        nextCycle();
        busCycle(1, 0, 32'h8040_0000, '0, 4'hF, 1, 0, 0, 32'hCAFE_F00D, "simul.mem");
        applyStimulus(1, 32'h8000_0100, 0, 0, '0, '0, '0);
        nextCycle();
        checkOutput("simul.gapIfBusy", if_busy, 1);
        checkOutput("simul.gapCyc", wb_cyc_o, 0);
        nextCycle();
        busCycle(0, 0, 32'h8000_0100, '0, 4'hF, 0, 0, 0, 32'h1234_5678, "simul.if");
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        nextCycle();

        // Store with four wait states leaves load data untouched.
        applyStimulus(0, '0, 1, 1, 32'h8040_0010, 32'hDEAD_BEEF, 4'h3);
        nextCycle();
        busCycle(1, 1, 32'h8040_0010, 32'hDEAD_BEEF, 4'h3, 4, 0, 0, 32'h5555_AAAA, "store");
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        nextCycle();

        // Data request arriving during a fetch waits for the fetch to finish.
        applyStimulus(1, 32'h8000_0200, 0, 0, 32'h8040_0020, '0, 4'hF);
        nextCycle();
        busCycle(0, 0, 32'h8000_0200, '0, 4'hF, 2, 0, 1, 32'h0BAD_F00D, "nopre.if");
        applyStimulus(0, '0, 1, 0, 32'h8040_0020, '0, 4'hF);
        nextCycle();
        checkOutput("nopre.gapMemBusy", mem_busy, 1);
        checkOutput("nopre.gapCyc", wb_cyc_o, 0);
        nextCycle();
        busCycle(1, 0, 32'h8040_0020, '0, 4'hF, 1, 0, 0, 32'h7777_1111, "nopre.mem");
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        nextCycle();

        // Flushed fetch still completes and captures data, but nothing reissues.
        applyStimulus(1, 32'h8000_0300, 0, 0, '0, '0, '0);
        nextCycle();
        busCycle(0, 0, 32'h8000_0300, '0, 4'hF, 3, 1, 0, 32'hF1F1_0303, "flush");
        nextCycle();
        nextCycle();
        checkOutput("flush.noReissue", wb_cyc_o, 0);

        // Randomized mix of fetches, loads, stores and simultaneous requests.
        for (int n = 0; n < 40; n++) begin
            kind  = $urandom_range(0, 3);
            waits = $urandom_range(0, 5);
            flush = ($urandom_range(0, 7) == 0);
            rndWe = (kind == 2) || ((kind == 3) && ($urandom_range(0, 1) == 1));
            ia    = $urandom;
            ma    = $urandom;
            wd    = $urandom;
            sel   = SW'($urandom);
            for (int k = 0; k < 20 && wb_cyc_o; k++) nextCycle();
            checkOutput("rnd.startIdle", wb_cyc_o, 0);
            wb_ack_i = 1'($urandom_range(0, 1));
            applyStimulus(kind == 0 || kind == 3, ia, kind != 0, rndWe, ma, wd, sel);
            checkOutput("rnd.idleIfBusy", if_busy, (kind == 0 || kind == 3));
            checkOutput("rnd.idleMemBusy", mem_busy, (kind != 0));
            checkOutput("rnd.idleCyc", wb_cyc_o, 0);
            nextCycle();
            if (kind == 0) begin
                busCycle(0, 0, ia, '0, {SW{1'b1}}, waits, flush, 0, DW'($urandom), "rnd.if");
            end else begin
                busCycle(1, rndWe, ma, wd, sel, waits, flush, 0, DW'($urandom), "rnd.mem");
                if (kind == 3) begin
                    applyStimulus(1, ia, 0, 0, '0, '0, '0);
                    nextCycle();
                    checkOutput("rnd.gapIfBusy", if_busy, 1);
                    checkOutput("rnd.gapCyc", wb_cyc_o, 0);
                    nextCycle();
                    busCycle(0, 0, ia, '0, {SW{1'b1}}, $urandom_range(0, 3), 0, 0,
                             DW'($urandom), "rnd.if2");
                end
            end
            applyStimulus(0, '0, 0, 0, '0, '0, '0);
            nextCycle();
            checkOutput("rnd.endCyc", wb_cyc_o, 0);
        end

        // Reset during an active strobe clears the bus without waiting for a clock.
        wb_ack_i = 1'b0;
        applyStimulus(1, 32'h8000_0400, 0, 0, '0, '0, '0);
        nextCycle();
        checkOutput("rstMid.stbBefore", wb_stb_o, 1);
        reset = 1'b0;
        #1;
        expIfRdata  = '0;
        expMemRdata = '0;
        checkOutput("rstMid.cyc", wb_cyc_o, 0);
        checkOutput("rstMid.stb", wb_stb_o, 0);
        checkOutput("rstMid.ifRdata", if_rdata, expIfRdata);
        checkOutput("rstMid.memRdata", mem_rdata, expMemRdata);
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        @(posedge clk);
        #1 reset = 1'b1;
        nextCycle();
        checkOutput("rstMid.idleCyc", wb_cyc_o, 0);
        applyStimulus(0, '0, 1, 0, 32'h8040_0030, '0, 4'hC);
        nextCycle();
        busCycle(1, 0, 32'h8040_0030, '0, 4'hC, 0, 0, 0, 32'h0000_0042, "rstMid.after");
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        nextCycle();

`ifdef BUS_TIMEOUT_EN
        // Slave never acknowledges: the cycle is aborted after TIMEOUT strobe cycles.
        wb_ack_i = 1'b0;
        applyStimulus(0, '0, 1, 0, 32'h8040_0040, '0, 4'hF);
        nextCycle();
        for (int c = 0; c < TIMEOUT; c++) begin
            checkOutput("tmo.stb", wb_stb_o, 1);
            checkOutput("tmo.errEarly", bus_err, 0);
            nextCycle();
        end
        expMemRdata = '0;
        checkOutput("tmo.stbDropped", wb_stb_o, 0);
        checkOutput("tmo.err", bus_err, 1);
        checkOutput("tmo.memRdata", mem_rdata, expMemRdata);
        checkOutput("tmo.memBusy", mem_busy, 0);
        applyStimulus(0, '0, 0, 0, '0, '0, '0);
        nextCycle();
        checkOutput("tmo.errPulse", bus_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
